sync_fifo_pro: RTL

Parametrised single-clock FIFO for the polar encoder datapath, buffering codeword and frozen-bit words between producer and consumer stages. Supports any integer DEPTH (not only powers of two), exact full/empty, programmable almost-full/almost-empty, an occupancy count, sticky overflow/underflow, and synchronous flush. Storage is an internal register array; the memory is not reset.

---
 rtl/sync_fifo_pro.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: parametrised single-clock FIFO for the polar encoder datapath.
// Any integer DEPTH, exact full/empty, programmable almost-full/almost-empty,
// occupancy count, sticky overflow/underflow and synchronous flush.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads; left undefined, reads have a registered one-cycle latency.
module sync_fifo_pro #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync_clr,
  input  logic                         winc,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         wfull,
  output logic                         walmost_full,
  input  logic                         rinc,
  output logic [WIDTH-1:0]             rdata,
  output logic                         rvalid,
  output logic                         rempty,
  output logic                         ralmost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic wacc;
  logic racc;

  // Acceptance uses the flags registered at the start of the cycle; a flush
  // cancels both sides so nothing reaches memory or the read port.
  assign wacc = winc & ~wfull_q & ~sync_clr;
  assign racc = rinc & ~rempty_q & ~sync_clr;

  // Next-state for pointers, occupancy and all flags, all derived from level_d
  // so the flags can never disagree with the count.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (sync_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wacc) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      if (racc) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      level_d = level_q + LW'(wacc) - LW'(racc);
      if (winc && wfull_q)  ovf_d = 1'b1;
      if (rinc && rempty_q) udf_d = 1'b1;
    end
    wfull_d  = (level_d == LVL_FULL);
    rempty_d = (level_d == '0);
    afull_d  = (level_d >= LVL_AF);
    aempty_d = (level_d <= LVL_AE);
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array, deliberately not reset; stale words are unreachable after
  // a flush because the pointers restart together.
  always_ff @(posedge clk) begin
    if (wacc) mem_q[wptr_q] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; forced to zero while empty so the
  // port never shows uninitialised storage.
  always_comb begin
    rdata  = rempty_q ? '0 : mem_q[rptr_q];
    rvalid = ~rempty_q;
  end
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  // Registered read port: data captured on an accepted read, held otherwise;
  // rvalid pulses for the cycle following each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= racc;
      if (racc) rdata_q <= mem_q[rptr_q];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule
